// File: rtl/mdu_stage.sv
// E-stage multiply/divide unit: multi-cycle MULT/DIV into HI/LO, single-cycle MTHI/MTLO.
// The result is computed at issue from the captured operands and committed after a fixed latency.
module mdu_stage #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        busy,
    output logic        stall_req,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    // state    | meaning
    // S_IDLE   | accepts MDU ops; MTHI/MTLO write immediately
    // S_BUSY   | counting down a multi-cycle op; pending result commits on 1->0
    typedef enum logic {S_IDLE, S_BUSY} state_e;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d, pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic signed [63:0] prod_s;
    logic [63:0] prod_u;
    logic        div_signed;
    logic [31:0] rs_mag, rt_mag, num, den_raw, den, quo, rem, div_hi, div_lo;

    // Products and quotient/remainder from the live operands; captured only at issue.
    // Signed divide works on magnitudes so 0x80000000 / -1 wraps to 0x80000000 without overflow.
    always_comb begin
        prod_s     = $signed({{32{rs[31]}}, rs}) * $signed({{32{rt[31]}}, rt});
        prod_u     = {32'd0, rs} * {32'd0, rt};
        div_signed = (op == 3'd2);
        rs_mag     = rs[31] ? -rs : rs;
        rt_mag     = rt[31] ? -rt : rt;
        num        = div_signed ? rs_mag : rs;
        den_raw    = div_signed ? rt_mag : rt;
        den        = (den_raw == 32'd0) ? 32'd1 : den_raw;
        quo        = num / den;
        rem        = num % den;
        div_lo     = (div_signed && (rs[31] ^ rt[31])) ? -quo : quo;
        div_hi     = (div_signed && rs[31]) ? -rem : rem;
    end

    // Next-state logic: issue, countdown and commit.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    case (op)
                        3'd0: begin
                            pend_hi_d = prod_s[63:32];
                            pend_lo_d = prod_s[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = MULT_LOAD;
                            state_d   = S_BUSY;
                        end
                        3'd1: begin
                            pend_hi_d = prod_u[63:32];
                            pend_lo_d = prod_u[31:0];
                            pend_wr_d = 1'b1;
                            cnt_d     = MULT_LOAD;
                            state_d   = S_BUSY;
                        end
                        3'd2, 3'd3: begin
                            pend_hi_d = div_hi;
                            pend_lo_d = div_lo;
                            // divide by zero runs full latency but leaves HI/LO alone
                            pend_wr_d = (rt != 32'd0);
                            cnt_d     = DIV_LOAD;
                            state_d   = S_BUSY;
                        end
                        3'd4: hi_d = rs;
                        3'd5: lo_d = rs;
                        default: ;
                    endcase
                end
            end
            S_BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q <= 4'd1) begin
                    cnt_d   = 4'd0;
                    state_d = S_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    pend_wr_d = 1'b0;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous active-low reset; reset aborts any op in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= 4'd0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy      = (state_q == S_BUSY);
    assign stall_req = busy | (start & ~op[2]);
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mdu_stage.sv
// Self-checking bench for mdu_stage: directed cases plus random ops against an arithmetic model.
module tb_mdu_stage;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        start;
    logic [2:0]  op;
    logic [31:0] rs, rt;
    logic        busy, stall_req;
    logic [31:0] hi, lo;

    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] m_hi, m_lo;

    mdu_stage dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .start     (start),
        .op        (op),
        .rs        (rs),
        .rt        (rt),
        .busy      (busy),
        .stall_req (stall_req),
        .hi        (hi),
        .lo        (lo)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Architectural result of one op: {hi, lo}
    function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] a,
                                               input logic [31:0] b, input logic [31:0] h,
                                               input logic [31:0] l);
        longint n, d, q, r;
        logic [63:0] p;
        case (o)
            3'd0: begin
                n = longint'($signed(a));
                d = longint'($signed(b));
                p = n * d;
                return p;
            end
            3'd1: return {32'd0, a} * {32'd0, b};
            3'd2: begin
                if (b == 0) return {h, l};
                n = longint'($signed(a));
                d = longint'($signed(b));
                q = n / d;
                r = n % d;
                return {r[31:0], q[31:0]};
            end
            3'd3: begin
                if (b == 0) return {h, l};
                return {a % b, a / b};
            end
            3'd4: return {a, l};
            3'd5: return {h, a};
            default: return {h, l};
        endcase
    endfunction

    // Called at a negedge; drives the op immediately and returns at the negedge
    // of the first non-busy cycle, so chained calls exercise back-to-back issue.
    task automatic issue(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                         input bit inject_mthi);
        logic [63:0] exp;
        int cnt;
        int lat;
        bit stall_ok;
        exp = ref_result(o, a, b, m_hi, m_lo);
        start = 1'b1; op = o; rs = a; rt = b;
        #1;
        check_eq($sformatf("stall_issue op%0d", o), {63'd0, stall_req}, {63'd0, (o <= 3'd3)});
        @(negedge clk);
        start = 1'b0;
        rs = $urandom; rt = $urandom;
        if (o <= 3'd3) begin
            lat = (o <= 3'd1) ? 5 : 10;
            cnt = 0;
            stall_ok = 1'b1;
            while (busy && cnt < 40) begin
                cnt++;
                if (!stall_req) stall_ok = 1'b0;
                // hi/lo must hold the previous values while busy
                if (hi !== m_hi || lo !== m_lo) stall_ok = 1'b0;
                rs = $urandom; rt = $urandom;
                start = inject_mthi && (cnt == 2);
                op = start ? 3'd4 : o;
                @(negedge clk);
            end
            start = 1'b0;
            check_eq($sformatf("busy_cycles op%0d", o), 64'(cnt), 64'(lat));
            check_eq($sformatf("busy_hold op%0d", o), {63'd0, stall_ok}, 64'd1);
        end else begin
            check_eq($sformatf("busy_single op%0d", o), {63'd0, busy}, 64'd0);
            check_eq($sformatf("stall_after op%0d", o), {63'd0, stall_req}, 64'd0);
        end
        m_hi = exp[63:32];
        m_lo = exp[31:0];
        check_eq($sformatf("hilo op%0d a=%h b=%h", o, a, b), {hi, lo}, exp);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;
        int k;
        reset_n = 1'b0; start = 1'b0; op = 3'd0; rs = 32'd0; rt = 32'd0;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (3) @(negedge clk);
        check_eq("reset_busy", {63'd0, busy}, 64'd0);
        check_eq("reset_stall", {63'd0, stall_req}, 64'd0);
        check_eq("reset_hilo", {hi, lo}, 64'd0);
        reset_n = 1'b1;
        @(negedge clk);

        // directed cases
        issue(3'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
        check_eq("mult_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
        issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
        check_eq("multu_const", {hi, lo}, 64'h00000002_FFFFFFFA);
        issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
        check_eq("div_const", {hi, lo}, 64'hFFFFFFFF_FFFFFFFD);
        issue(3'd3, 32'hFFFFFFF9, 32'd2, 1'b0);
        check_eq("divu_const", {hi, lo}, 64'h00000001_7FFFFFFC);
        issue(3'd4, 32'h12345678, 32'd0, 1'b0);
        issue(3'd5, 32'h9ABCDEF0, 32'd0, 1'b0);
        check_eq("mthi_mtlo", {hi, lo}, 64'h12345678_9ABCDEF0);
        issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
        check_eq("div_ovf", {hi, lo}, 64'h00000000_80000000);
        issue(3'd4, 32'd5, 32'd0, 1'b0);
        issue(3'd5, 32'd7, 32'd0, 1'b0);
        issue(3'd3, 32'd1234, 32'd0, 1'b0);
        check_eq("divu_zero", {hi, lo}, 64'h00000005_00000007);
        issue(3'd0, 32'd100, 32'hFFFFFFF6, 1'b1);
        check_eq("mult_capture", {hi, lo}, 64'hFFFFFFFF_FFFFFC18);
        issue(3'd6, 32'hDEADBEEF, 32'd1, 1'b0);
        issue(3'd7, 32'hDEADBEEF, 32'd1, 1'b0);

        // reset in the 4th busy cycle of a DIV
        start = 1'b1; op = 3'd2; rs = 32'd1000; rt = 32'd3;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("pre_abort_busy", {63'd0, busy}, 64'd1);
        reset_n = 1'b0;
        @(negedge clk);
        check_eq("abort_busy", {63'd0, busy}, 64'd0);
        check_eq("abort_hilo", {hi, lo}, 64'd0);
        reset_n = 1'b1;
        m_hi = 32'd0; m_lo = 32'd0;
        repeat (12) @(negedge clk);
        check_eq("no_late_commit", {hi, lo}, 64'd0);
        check_eq("no_late_busy", {63'd0, busy}, 64'd0);
        issue(3'd0, 32'h00010000, 32'h00010000, 1'b0);
        issue(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);

        // random back-to-back ops
        for (int i = 0; i < 60; i++) begin
            k  = $urandom_range(0, 9);
            ro = (k > 7) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 9) == 0) begin
                ra = 32'h80000000;
                rb = 32'hFFFFFFFF;
            end
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 17));
            issue(ro, ra, rb, $urandom_range(0, 3) == 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
